// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
package fetch_pkg;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;
    localparam int DEPTH  = 2;

    typedef enum logic {
        IDLE,
        REQ
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the pc, instruction-memory and decode channels of the fetch unit.
interface fetch_unit_if #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int INST_W = fetch_pkg::INST_W
);
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              pc_ready;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              fault;

    modport master (
        input  pc, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output pc_ready, imem_req, imem_addr, inst, inst_pc, inst_valid, fault
    );

    modport slave (
        output pc, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  pc_ready, imem_req, imem_addr, inst, inst_pc, inst_valid, fault
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and a clear that wins over push/pop.
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 96
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  logic [DATA_W-1:0]            data_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              doPush, doPop;

    function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = incPtr(wrPtr_q);
            if (doPop)  rdPtr_d = incPtr(rdPtr_q);
            count_d = count_q + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush && !clear_i) mem_q[wrPtr_q] <= data_i;
    end

    noOverflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push_i && !clear_i) |-> (!full_o || pop_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one memory read per accepted pc, tracks
// in-flight reads with credits and drops responses that a branch flush made stale.
module fetch_unit #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int INST_W = fetch_pkg::INST_W,
    parameter int DEPTH  = fetch_pkg::DEPTH
) (
    input logic          clk_i,
    input logic          rst_ni,
    fetch_unit_if.master bus
);
    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = DEPTH[CW:0];

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               fault_q, fault_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [CW-1:0]      discard_q, discard_d;
    logic [CW:0]        creditUsed;
    logic               accept, grant, rsp, push, pop;
    logic               bufEmpty;
    logic [CW-1:0]      bufCount;
    logic [ADDR_W+INST_W-1:0] bufHead;
    logic [ADDR_W-1:0]  rspAddr;
    logic               unusedBufFull, unusedAddrFull, unusedAddrEmpty;
    logic [CW-1:0]      unusedAddrCount;

    // Outstanding reads plus buffered entries never exceed DEPTH, so the buffer cannot overflow.
    assign creditUsed   = {1'b0, outstanding_q} + {1'b0, bufCount};
    assign bus.pc_ready = rst_ni && (state_q == IDLE) && !bus.flush && (creditUsed < CREDITS);

    assign accept = bus.pc_valid && bus.pc_ready;
    assign grant  = (state_q == REQ) && bus.imem_gnt;
    assign rsp    = bus.imem_rvalid && (outstanding_q != '0);
    assign push   = rsp && (discard_q == '0) && !bus.flush;
    assign pop    = !bufEmpty && bus.inst_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.pc[1:0] == 2'b00) begin
                        addr_d  = bus.pc;
                        state_d = REQ;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.imem_gnt || bus.flush) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // On flush every read still in flight after this cycle, including one granted now, becomes stale.
    always_comb begin
        outstanding_d = outstanding_q + CW'(grant) - CW'(rsp);
        discard_d     = discard_q;
        if (bus.flush) begin
            discard_d = outstanding_d;
        end else if (rsp && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            fault_q       <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            fault_q       <= fault_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .DATA_W(ADDR_W)) addrFifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .pop_i   (rsp),
        .clear_i (1'b0),
        .data_i  (addr_q),
        .data_o  (rspAddr),
        .full_o  (unusedAddrFull),
        .empty_o (unusedAddrEmpty),
        .count_o (unusedAddrCount)
    );

    fetch_fifo #(.DEPTH(DEPTH), .DATA_W(ADDR_W + INST_W)) instFifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (bus.flush),
        .data_i  ({rspAddr, bus.imem_rdata}),
        .data_o  (bufHead),
        .full_o  (unusedBufFull),
        .empty_o (bufEmpty),
        .count_o (bufCount)
    );

    assign bus.imem_req   = (state_q == REQ);
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = !bufEmpty;
    assign bus.inst       = bufEmpty ? '0 : bufHead[INST_W-1:0];
    assign bus.inst_pc    = bufEmpty ? '0 : bufHead[ADDR_W+INST_W-1:INST_W];
    assign bus.fault      = fault_q;

    rvalidNeedsOutstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.imem_rvalid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycle tables, corner-case sequences
// and a randomized run against a queue-based reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic        pcValid;
        logic [63:0] pc;
        logic        flush;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        instReady;
        logic        expPcReady;
        logic        expReq;
        logic [63:0] expAddr;
        logic        expInstValid;
        logic [31:0] expInst;
        logic [63:0] expInstPc;
        logic        expFault;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        bit          dropped;
    } flight_t;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    vec_t tbl [20];

    entry_t      bufQ[$];
    flight_t     flightQ[$];
    bit          busy;
    logic [63:0] reqAddr;
    bit          faultPend;

    fetch_unit_if bus();

    fetch_unit dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic pv, input logic [63:0] pc, input logic fl,
                                   input logic gn, input logic rv, input logic [31:0] rd,
                                   input logic ir, input logic epr, input logic ereq,
                                   input logic [63:0] ea, input logic eiv, input logic [31:0] ei,
                                   input logic [63:0] eipc, input logic ef);
        vec_t v;
        v.pcValid = pv;  v.pc = pc;  v.flush = fl;  v.gnt = gn;  v.rvalid = rv;
        v.rdata = rd;  v.instReady = ir;  v.expPcReady = epr;  v.expReq = ereq;
        v.expAddr = ea;  v.expInstValid = eiv;  v.expInst = ei;  v.expInstPc = eipc;
        v.expFault = ef;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveIdle();
        bus.pc_valid    = 1'b0;
        bus.pc          = '0;
        bus.flush       = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_ready  = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        bus.pc_valid    = v.pcValid;
        bus.pc          = v.pc;
        bus.flush       = v.flush;
        bus.imem_gnt    = v.gnt;
        bus.imem_rvalid = v.rvalid;
        bus.imem_rdata  = v.rdata;
        bus.inst_ready  = v.instReady;
        #1;
    endtask

    task automatic runVec(input string name, input vec_t v);
        applyStimulus(v);
        checkOutput({name, ".pc_ready"},   64'(bus.pc_ready),   64'(v.expPcReady));
        checkOutput({name, ".imem_req"},   64'(bus.imem_req),   64'(v.expReq));
        checkOutput({name, ".imem_addr"},  bus.imem_addr,       v.expAddr);
        checkOutput({name, ".inst_valid"}, 64'(bus.inst_valid), 64'(v.expInstValid));
        checkOutput({name, ".inst"},       64'(bus.inst),       64'(v.expInst));
        checkOutput({name, ".inst_pc"},    bus.inst_pc,         v.expInstPc);
        checkOutput({name, ".fault"},      64'(bus.fault),      64'(v.expFault));
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, ".pc_ready"},   64'(bus.pc_ready),   64'h0);
        checkOutput({name, ".imem_req"},   64'(bus.imem_req),   64'h0);
        checkOutput({name, ".imem_addr"},  bus.imem_addr,       64'h0);
        checkOutput({name, ".inst_valid"}, 64'(bus.inst_valid), 64'h0);
        checkOutput({name, ".inst"},       64'(bus.inst),       64'h0);
        checkOutput({name, ".inst_pc"},    bus.inst_pc,         64'h0);
        checkOutput({name, ".fault"},      64'(bus.fault),      64'h0);
    endtask

    task automatic doReset(input string name);
        rst_n = 1'b0;
        driveIdle();
        #1;
        checkResetOutputs(name);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        driveIdle();

        // Rows: pv, pc, flush, gnt, rvalid, rdata, inst_ready | pc_ready, req, addr, inst_valid, inst, inst_pc, fault
        tbl[0]  = mkVec(H, 64'h0, L, L, L, 32'h0,        L,  H, L, 64'h0, L, 32'h0,        64'h0, L);
        tbl[1]  = mkVec(L, 64'h0, L, H, L, 32'h0,        L,  L, H, 64'h0, L, 32'h0,        64'h0, L);
        tbl[2]  = mkVec(L, 64'h0, L, L, H, 32'hF8400020, L,  H, L, 64'h0, L, 32'h0,        64'h0, L);
        tbl[3]  = mkVec(L, 64'h0, L, L, L, 32'h0,        H,  H, L, 64'h0, H, 32'hF8400020, 64'h0, L);
        tbl[4]  = mkVec(L, 64'h0, L, L, L, 32'h0,        L,  H, L, 64'h0, L, 32'h0,        64'h0, L);
        tbl[5]  = mkVec(H, 64'h2, L, L, L, 32'h0,        L,  H, L, 64'h0, L, 32'h0,        64'h0, L);
        tbl[6]  = mkVec(L, 64'h0, L, L, L, 32'h0,        L,  H, L, 64'h0, L, 32'h0,        64'h0, H);
        tbl[7]  = mkVec(L, 64'h0, L, L, L, 32'h0,        L,  H, L, 64'h0, L, 32'h0,        64'h0, L);
        tbl[8]  = mkVec(H, 64'h0, L, L, L, 32'h0,        L,  H, L, 64'h0, L, 32'h0,        64'h0, L);
        tbl[9]  = mkVec(L, 64'h0, L, H, L, 32'h0,        L,  L, H, 64'h0, L, 32'h0,        64'h0, L);
        tbl[10] = mkVec(H, 64'h4, L, L, L, 32'h0,        L,  H, L, 64'h0, L, 32'h0,        64'h0, L);
        tbl[11] = mkVec(L, 64'h0, L, H, H, 32'h11111111, L,  L, H, 64'h4, L, 32'h0,        64'h0, L);
        tbl[12] = mkVec(H, 64'h8, L, L, H, 32'h22222222, L,  L, L, 64'h4, H, 32'h11111111, 64'h0, L);
        tbl[13] = mkVec(H, 64'h8, L, L, L, 32'h0,        L,  L, L, 64'h4, H, 32'h11111111, 64'h0, L);
        tbl[14] = mkVec(H, 64'h8, L, L, L, 32'h0,        H,  L, L, 64'h4, H, 32'h11111111, 64'h0, L);
        tbl[15] = mkVec(H, 64'h8, L, L, L, 32'h0,        H,  H, L, 64'h4, H, 32'h22222222, 64'h4, L);
        tbl[16] = mkVec(L, 64'h0, L, H, L, 32'h0,        L,  L, H, 64'h8, L, 32'h0,        64'h0, L);
        tbl[17] = mkVec(L, 64'h0, L, L, H, 32'h33333333, L,  H, L, 64'h8, L, 32'h0,        64'h0, L);
        tbl[18] = mkVec(L, 64'h0, L, L, L, 32'h0,        H,  H, L, 64'h8, H, 32'h33333333, 64'h8, L);
        tbl[19] = mkVec(L, 64'h0, L, L, L, 32'h0,        L,  H, L, 64'h8, L, 32'h0,        64'h0, L);

        $display("[TB] reset and directed table");
        doReset("reset");
        for (int i = 0; i < 20; i++) runVec($sformatf("tbl%0d", i), tbl[i]);

        $display("[TB] flush with two reads in flight");
        runVec("flush0",  mkVec(H, 64'h0,  L, L, L, 32'h0,        H,  H, L, 64'h8,  L, 32'h0, 64'h0, L));
        runVec("flush1",  mkVec(L, 64'h0,  L, H, L, 32'h0,        H,  L, H, 64'h0,  L, 32'h0, 64'h0, L));
        runVec("flush2",  mkVec(H, 64'h4,  L, L, L, 32'h0,        H,  H, L, 64'h0,  L, 32'h0, 64'h0, L));
        runVec("flush3",  mkVec(L, 64'h0,  L, H, L, 32'h0,        H,  L, H, 64'h4,  L, 32'h0, 64'h0, L));
        runVec("flush4",  mkVec(L, 64'h0,  H, L, L, 32'h0,        H,  L, L, 64'h4,  L, 32'h0, 64'h0, L));
        runVec("flush5",  mkVec(L, 64'h0,  L, L, H, 32'hDEAD0001, H,  L, L, 64'h4,  L, 32'h0, 64'h0, L));
        runVec("flush6",  mkVec(L, 64'h0,  L, L, H, 32'hDEAD0002, H,  H, L, 64'h4,  L, 32'h0, 64'h0, L));
        runVec("flush7",  mkVec(H, 64'h40, L, L, L, 32'h0,        H,  H, L, 64'h4,  L, 32'h0, 64'h0, L));
        runVec("flush8",  mkVec(L, 64'h0,  L, H, L, 32'h0,        H,  L, H, 64'h40, L, 32'h0, 64'h0, L));
        runVec("flush9",  mkVec(L, 64'h0,  L, L, H, 32'hAABBCCDD, H,  H, L, 64'h40, L, 32'h0, 64'h0, L));
        runVec("flush10", mkVec(L, 64'h0,  L, L, L, 32'h0,        H,  H, L, 64'h40, H, 32'hAABBCCDD, 64'h40, L));
        runVec("flush11", mkVec(L, 64'h0,  L, L, L, 32'h0,        L,  H, L, 64'h40, L, 32'h0, 64'h0, L));
        checkOutput("flush.discard", 64'(dut.discard_q), 64'h0);

        $display("[TB] grant stall");
        runVec("stall0", mkVec(H, 64'h100, L, L, L, 32'h0, L,  H, L, 64'h40, L, 32'h0, 64'h0, L));
        for (int i = 1; i <= 5; i++)
            runVec($sformatf("stall%0d", i), mkVec(H, 64'h200, L, L, L, 32'h0, L,  L, H, 64'h100, L, 32'h0, 64'h0, L));
        runVec("stall6", mkVec(L, 64'h0, L, H, L, 32'h0,  L,  L, H, 64'h100, L, 32'h0,  64'h0,   L));
        runVec("stall7", mkVec(L, 64'h0, L, L, H, 32'h13, L,  H, L, 64'h100, L, 32'h0,  64'h0,   L));
        runVec("stall8", mkVec(L, 64'h0, L, L, L, 32'h0,  H,  H, L, 64'h100, H, 32'h13, 64'h100, L));
        runVec("stall9", mkVec(L, 64'h0, L, L, L, 32'h0,  L,  H, L, 64'h100, L, 32'h0,  64'h0,   L));

        $display("[TB] reset during a request");
        runVec("mid0", mkVec(H, 64'h300, L, L, L, 32'h0, L,  H, L, 64'h100, L, 32'h0, 64'h0, L));
        runVec("mid1", mkVec(L, 64'h0,   L, H, L, 32'h0, L,  L, H, 64'h300, L, 32'h0, 64'h0, L));
        runVec("mid2", mkVec(H, 64'h304, L, L, L, 32'h0, L,  H, L, 64'h300, L, 32'h0, 64'h0, L));
        @(posedge clk);
        #1;
        driveIdle();
        #1;
        checkOutput("mid.in_req", 64'(bus.imem_req), 64'h1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid.async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) runVec($sformatf("post_rst%0d", i), tbl[i]);

        $display("[TB] randomized run against reference model");
        doReset("rnd_reset");
        bufQ.delete();
        flightQ.delete();
        busy = 0;
        reqAddr = '0;
        faultPend = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        pv, fl, gn, rv, ir, expPr, acc;
            logic [63:0] pcR;
            logic [31:0] rd;
            flight_t     f;
            @(posedge clk);
            #1;
            pv  = ($urandom_range(0, 2) != 0);
            pcR = {$urandom, $urandom};
            pcR[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fl  = ($urandom_range(0, 9) == 0);
            gn  = busy && ($urandom_range(0, 2) != 0);
            rv  = (flightQ.size() > 0) && ($urandom_range(0, 1) == 1);
            rd  = $urandom;
            ir  = ($urandom_range(0, 3) != 0);
            bus.pc_valid = pv;  bus.pc = pcR;  bus.flush = fl;  bus.imem_gnt = gn;
            bus.imem_rvalid = rv;  bus.imem_rdata = rd;  bus.inst_ready = ir;
            #1;
            expPr = !busy && !fl && ((flightQ.size() + bufQ.size()) < DEPTH);
            checkOutput("rnd.pc_ready",   64'(bus.pc_ready),   64'(expPr));
            checkOutput("rnd.imem_req",   64'(bus.imem_req),   64'(busy));
            checkOutput("rnd.inst_valid", 64'(bus.inst_valid), 64'(bufQ.size() > 0));
            checkOutput("rnd.fault",      64'(bus.fault),      64'(faultPend));
            if (busy) checkOutput("rnd.imem_addr", bus.imem_addr, reqAddr);
            if (bufQ.size() > 0) begin
                checkOutput("rnd.inst",    64'(bus.inst), 64'(bufQ[0].inst));
                checkOutput("rnd.inst_pc", bus.inst_pc,   bufQ[0].pc);
            end

            acc = pv && expPr;
            if (bufQ.size() > 0 && ir) void'(bufQ.pop_front());
            if (rv) begin
                f = flightQ.pop_front();
                if (!f.dropped && !fl) bufQ.push_back('{pc: f.addr, inst: rd});
            end
            if (busy && gn) begin
                flightQ.push_back('{addr: reqAddr, dropped: 1'b0});
                busy = 0;
            end else if (busy && fl) begin
                busy = 0;
            end
            if (fl) begin
                foreach (flightQ[i]) flightQ[i].dropped = 1'b1;
                bufQ.delete();
            end
            faultPend = 0;
            if (acc) begin
                if (pcR[1:0] == 2'b00) begin
                    busy = 1;
                    reqAddr = pcR;
                end else begin
                    faultPend = 1;
                end
            end
        end

        driveIdle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, 64, instruction address width (matches program-counter width).
REQ-002 Parameter INST_W, 32, instruction word width.
REQ-003 Parameter DEPTH, 2, instruction-buffer entries; also the maximum outstanding-plus-buffered fetches.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 pc  input  ADDR_W  fetch address from the program counter.
REQ-007 pc_valid  input  1  pc holds a fetch address.
REQ-008 pc_ready  output  1  pc accepted this cycle when pc_valid is also high.
REQ-009 flush  input  1  branch taken (Branch&ZeroFlag or UncondBranch); discard all older fetches.
REQ-010 imem_req  output  1  memory read request.
REQ-011 imem_addr  output  ADDR_W  memory read address.
REQ-012 imem_gnt  input  1  memory accepted the request.
REQ-013 imem_rvalid  input  1  read data returned, in request order.
REQ-014 imem_rdata  input  INST_W  returned instruction word.
REQ-015 inst  output  INST_W  buffered instruction to decode.
REQ-016 inst_pc  output  ADDR_W  address of inst.
REQ-017 inst_valid  output  1  inst/inst_pc valid.
REQ-018 inst_ready  input  1  decode consumes the entry when inst_valid is also high.
REQ-019 fault  output  1  one-cycle pulse: misaligned pc accepted.

Function
REQ-020 FSM states IDLE, REQ; reset state IDLE.
REQ-021 pc_ready SHALL be 1 only in IDLE, with flush low and (outstanding + occupancy) < DEPTH.
REQ-022 Accepted pc with pc[1:0]==0: latch pc, go to REQ; imem_req=1 and imem_addr=latched pc from the next cycle.
REQ-023 In REQ, imem_req and imem_addr SHALL stay stable until imem_gnt; on gnt, outstanding+1, go to IDLE.
REQ-024 Accepted pc with pc[1:0]!=0: no memory request, fault=1 the next cycle only, FSM stays IDLE.
REQ-025 imem_rvalid with discard==0: push {pc, rdata} into buffer, outstanding-1; inst_valid rises the cycle after rvalid.
REQ-026 Latency: pc accepted cycle N, gnt at N+1, rvalid at N+2 -> inst_valid at N+3.
REQ-027 Pop on inst_valid&inst_ready; simultaneous push and pop SHALL keep occupancy unchanged, order preserved.
REQ-028 Credit rule (REQ-021) SHALL guarantee no overflow; buffer full with rvalid is impossible by construction.
REQ-029 flush: buffer emptied next cycle, discard += outstanding, REQ state without same-cycle gnt drops to IDLE (imem_req low next cycle).
REQ-030 flush with same-cycle imem_gnt: that request counts as outstanding and discarded.
REQ-031 flush with same-cycle imem_rvalid: that response is discarded.
REQ-032 Response while discard>0: dropped, discard-1, outstanding-1, no push.
REQ-033 inst_valid SHALL be 0 in the cycle after flush.
REQ-034 pc_ready SHALL be low during flush; the new target is accepted no earlier than the following cycle.
REQ-035 imem_rvalid with outstanding==0 is a protocol error: ignored, flagged by assertion.
REQ-036 Counters outstanding/discard SHALL be ceil(log2(DEPTH+1)) bits; neither wraps.

Reset
REQ-037 rst low SHALL immediately force: FSM IDLE, buffer empty, outstanding=0, discard=0.
REQ-038 During reset: pc_ready=0, imem_req=0, imem_addr=0, inst=0, inst_pc=0, inst_valid=0, fault=0.
REQ-039 Reset mid-transaction abandons in-flight reads; the memory is reset in the same domain.

Structure
REQ-040 Shared package fetch_pkg: ADDR_W, INST_W, DEPTH defaults, FSM state type, buffer entry type {pc, inst}.
REQ-041 Sub-module fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, full, empty, count, clear.
REQ-042 fetch_unit holds the FSM, credit/discard counters and flush logic only.

Verification
REQ-043 pc=0x0, gnt immediate, rvalid one cycle later with 0xF8400020 -> inst_valid at N+3, inst=0xF8400020, inst_pc=0x0.
REQ-044 inst_ready=0, fetch 0x0 and 0x4 -> buffer full, pc_ready=0 for 0x8 until one pop.
REQ-045 Two granted reads at 0x0/0x4, flush, rvalid x2, then fetch 0x40 -> only the 0x40 entry appears, discard returns to 0.
REQ-046 pc=0x2 accepted -> fault pulses 1 cycle, imem_req stays 0, inst_valid stays 0.
REQ-047 imem_gnt held low 5 cycles -> imem_req/imem_addr stable throughout, pc_ready=0.
REQ-048 rst asserted low while in REQ with outstanding=1 -> all outputs 0 immediately, first fetch after release behaves as REQ-043.
